// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit:
// operation codes, FSM states and the default datapath width.
package md_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Shared shift-add / restoring shift-subtract magnitude datapath.
// One WIDTH+1 adder serves both modes; {hi,lo} hold {prod} or {rem,quot}.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   w_x;
  logic [WIDTH:0]   w_y;
  logic [WIDTH:0]   w_sum;
  logic             w_borrow;

  // Operand select for the shared adder; divide subtracts via ~y + 1.
  always_comb begin
    w_x = {1'b0, r_hi};
    w_y = '0;
    if (i_div) begin
      w_x = {r_hi, r_lo[WIDTH-1]};
      w_y = ~{1'b0, r_b};
    end else if (r_lo[0]) begin
      w_y = {1'b0, r_b};
    end
    w_sum    = w_x + w_y + {{WIDTH{1'b0}}, i_div};
    w_borrow = w_sum[WIDTH];
  end

  // One iteration per step: shift-add right or shift-subtract left.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
      r_b  <= '0;
    end else if (i_load) begin
      r_hi <= '0;
      r_lo <= i_a;
      r_b  <= i_b;
    end else if (i_step) begin
      if (i_div) begin
        r_hi <= w_borrow ? w_x[WIDTH-1:0] : w_sum[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], ~w_borrow};
      end else begin
        {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/DIV unit with HI/LO registers for the 5-stage core.
// FSM: IDLE -> CALC (ITER cycles) -> FIX (sign fixup, HI/LO write).
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam int CW = $clog2(ITER + 1);

  md_state_e        r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_mhi;
  logic [WIDTH-1:0] w_mlo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  // Magnitudes and sign flags of the incoming operands.
  always_comb begin
    w_signed = (op == MD_MULT) || (op == MD_DIV);
    w_a_neg  = w_signed & src_a[WIDTH-1];
    w_b_neg  = w_signed & src_b[WIDTH-1];
    w_a_mag  = w_a_neg ? (~src_a + 1'b1) : src_a;
    w_b_mag  = w_b_neg ? (~src_b + 1'b1) : src_b;
    w_accept = start & ~flush & (r_state == S_IDLE);
    w_load   = w_accept & ~op[2];
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .resetn (resetn),
    .i_load (w_load),
    .i_step (r_state == S_CALC),
    .i_div  (r_div),
    .i_a    (w_a_mag),
    .i_b    (w_b_mag),
    .o_hi   (w_mhi),
    .o_lo   (w_mlo)
  );

  // Sign correction of the magnitude results.
  always_comb begin
    w_prod = {w_mhi, w_mlo};
    if (r_neg_q) w_prod = ~w_prod + 1'b1;
    w_quot = r_neg_q ? (~w_mlo + 1'b1) : w_mlo;
    w_rem  = r_neg_r ? (~w_mhi + 1'b1) : w_mhi;
  end

  // Control FSM with registered busy/done and the HI/LO registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                r_state <= S_CALC;
                r_cnt   <= '0;
                r_div   <= op[1];
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                busy    <= 1'b1;
              end
              MD_MTHI: hi <= src_a;
              MD_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else if (r_cnt == CW'(ITER - 1)) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (r_div) begin
              lo <= w_quot;
              hi <= w_rem;
            end else begin
              {hi, lo} <= w_prod;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed table-driven bench for mul_div_unit plus hand-written
// sequences for MTHI/MTLO, busy-time writes, flush and reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[$];

  mul_div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles, then check done/hi/lo and the done pulse width.
  task automatic finish_op(input string nm, input logic [31:0] ehi,
                           input logic [31:0] elo);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, cnt, 32'd33);
    chk({nm, " done"}, {31'd0, done}, 32'd1);
    chk({nm, " hi"}, hi, ehi);
    chk({nm, " lo"}, lo, elo);
    @(negedge clk);
    chk({nm, " done_pulse_end"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] shi;
    logic [31:0] slo;
    int seen;

    vecs.push_back('{"mult_m1x2", 3'd0, 32'hFFFFFFFF, 32'h2,
                     32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{"multu_m1x2", 3'd1, 32'hFFFFFFFF, 32'h2,
                     32'h00000001, 32'hFFFFFFFE});
    vecs.push_back('{"multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"mult_7xm3", 3'd0, 32'h7, 32'hFFFFFFFD,
                     32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{"div_m7_2", 3'd2, 32'hFFFFFFF9, 32'h2,
                     32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_7_2", 3'd3, 32'h7, 32'h2,
                     32'h1, 32'h3});
    vecs.push_back('{"divu_by0", 3'd3, 32'h1234, 32'h0,
                     32'h1234, 32'hFFFFFFFF});
    vecs.push_back('{"div_7_0", 3'd2, 32'h7, 32'h0,
                     32'h7, 32'hFFFFFFFF});
    vecs.push_back('{"div_m7_0", 3'd2, 32'hFFFFFFF9, 32'h0,
                     32'hFFFFFFF9, 32'h00000001});
    vecs.push_back('{"div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF,
                     32'h0, 32'h80000000});
    vecs.push_back('{"div_100_m7", 3'd2, 32'd100, 32'hFFFFFFF9,
                     32'd2, 32'hFFFFFFF2});
    vecs.push_back('{"div_m100_7", 3'd2, 32'hFFFFFF9C, 32'd7,
                     32'hFFFFFFFE, 32'hFFFFFFF2});
    vecs.push_back('{"divu_max_10", 3'd3, 32'hFFFFFFFF, 32'd10,
                     32'd5, 32'h19999999});

    resetn = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    src_a  = '0;
    src_b  = '0;
    flush  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      finish_op(vecs[i].name, vecs[i].ehi, vecs[i].elo);
    end

    // MTHI / MTLO while idle
    issue(3'd4, 32'hA5A5A5A5, 32'h0);
    chk("mthi hi", hi, 32'hA5A5A5A5);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    issue(3'd5, 32'h5A5A5A5A, 32'h0);
    chk("mtlo lo", lo, 32'h5A5A5A5A);
    chk("mtlo hi", hi, 32'hA5A5A5A5);
    chk("mtlo busy", {31'd0, busy}, 32'd0);

    // no-op codes
    issue(3'd6, 32'h1111, 32'h2222);
    issue(3'd7, 32'h3333, 32'h4444);
    chk("nop hi", hi, 32'hA5A5A5A5);
    chk("nop lo", lo, 32'h5A5A5A5A);
    chk("nop busy", {31'd0, busy}, 32'd0);

    // flush with start in idle: flush wins
    @(negedge clk);
    flush = 1'b1;
    issue(3'd4, 32'hDEADBEEF, 32'h0);
    flush = 1'b0;
    chk("flushstart hi", hi, 32'hA5A5A5A5);
    @(negedge clk);
    chk("flushstart busy", {31'd0, busy}, 32'd0);

    // MTHI/MTLO while busy are ignored
    issue(3'd1, 32'd3, 32'd5);
    issue(3'd4, 32'h11111111, 32'h0);
    issue(3'd5, 32'h22222222, 32'h0);
    chk("busy_mthi hi", hi, 32'hA5A5A5A5);
    chk("busy_mtlo lo", lo, 32'h5A5A5A5A);
    seen = 0;
    while (busy === 1'b1 && seen < 100) begin
      seen++;
      @(negedge clk);
    end
    chk("busy_mt done", {31'd0, done}, 32'd1);
    chk("busy_mt hi", hi, 32'd0);
    chk("busy_mt lo", lo, 32'd15);
    @(negedge clk);

    // flush during CALC
    shi = hi;
    slo = lo;
    issue(3'd0, 32'h1000, 32'h1000);
    repeat (9) @(negedge clk);
    chk("calc_flush busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("calc_flush busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    chk("calc_flush no_done", seen, 32'd0);
    chk("calc_flush hi", hi, shi);
    chk("calc_flush lo", lo, slo);
    issue(3'd3, 32'd100, 32'd7);
    finish_op("divu_100_7", 32'd2, 32'd14);

    // flush in FIX (33rd busy cycle)
    shi = hi;
    slo = lo;
    issue(3'd1, 32'd9, 32'd9);
    repeat (32) @(negedge clk);
    chk("fix_flush busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fix_flush busy", {31'd0, busy}, 32'd0);
    chk("fix_flush done", {31'd0, done}, 32'd0);
    chk("fix_flush hi", hi, shi);
    chk("fix_flush lo", lo, slo);

    // asynchronous reset mid-operation
    issue(3'd1, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst hi", hi, 32'd0);
    chk("arst lo", lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    finish_op("mult_after_rst", 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
- Holds `busy` while a multi-cycle operation runs. The hazard unit consumes `busy` to stall any HI/LO-touching instruction in decode.
- Provides HI/LO to the EX-stage MFHI/MFLO mux.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, WIDTH, number of shift-add/shift-subtract iterations.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  EX-stage request valid for one cycle.
- op  in  3  operation code from md_pkg: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are no-op.
- src_a  in  WIDTH  rs value (multiplicand, dividend, or MTHI/MTLO data).
- src_b  in  WIDTH  rt value (multiplier or divisor).
- flush  in  1  exception flush of the EX/MEM stages; aborts the in-flight operation.
- busy  out  1  registered; high while a multiply or divide is in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- done  out  1  one-cycle registered pulse in the cycle HI/LO first show a new mul/div result.

Behaviour:
Reset (resetn=0, asynchronous):
- state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.

FSM states:
- IDLE:
  - On start with MULT..DIVU and flush=0: latch operands and go to CALC. Signed ops latch |src_a| and |src_b| plus the sign flags.
  - On start with MTHI or MTLO: write src_a to hi or lo at that edge, stay in IDLE, busy stays 0.
  - On start with op 6 or 7: no effect.
- CALC:
  - Exactly ITER cycles, counter 0..ITER-1, one iteration per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract through a WIDTH+1-bit subtractor, producing quotient and remainder.
- FIX: one cycle. Apply sign correction and write hi/lo at the exiting edge; done=1 for the following cycle; return to IDLE.

Timing:
- start accepted at edge k → busy=1 for cycles k+1 .. k+ITER+1 (ITER+1 cycles).
- New hi/lo and done=1 visible from cycle k+ITER+2.
- busy=0 in that same cycle.

Result rules:
- MULT/MULTU: {hi,lo} = product. For MULT, the unsigned magnitude product is negated when the operand signs differ.
- DIV/DIVU: lo = quotient, hi = remainder.
  - Signed: quotient negative iff the operand signs differ; remainder takes the dividend's sign (truncation toward zero).
- Divide by zero (signed or unsigned): the magnitude datapath yields quotient magnitude all ones and remainder = |dividend|. The FIX sign rules are then applied unchanged. Required results:
  - DIVU by 0: lo=0xFFFFFFFF, hi=src_a.
  - DIV, non-negative dividend (e.g. 7/0): lo=0xFFFFFFFF, hi=7.
  - DIV, negative dividend (e.g. -7/0): quotient sign flips, so lo=0x00000001, hi=0xFFFFFFF9 (-7).
  - No exception is raised in any case.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000 (wraps), hi=0.

Boundary cases:
- start while busy=1: ignored; the hazard unit guarantees this does not occur. This includes MTHI/MTLO: hi/lo are not written.
- flush=1 in CALC or FIX: return to IDLE at the next edge, busy=0 next cycle, hi/lo unchanged, no done pulse.
- flush=1 and start=1 in the same IDLE cycle: flush wins; nothing is latched or written.
- Reset asserted mid-operation: immediately returns to the reset values.
- hi/lo change only at a FIX exit or an MTHI/MTLO write.

Decomposition:
- md_pkg: op encodings (MD_MULT..MD_MTLO), FSM state encodings, WIDTH default.
- Sub-module md_iter_core: shared shift/accumulate datapath with one WIDTH+1-bit adder/subtractor and a mode input (mul/div). It produces the {rem,quot} or {prod_hi,prod_lo} magnitudes. mul_div_unit keeps the FSM, sign handling and HI/LO registers.

Test Plan:
- MULT 0xFFFFFFFF × 0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy high for exactly 33 cycles, then done pulses for 1 cycle.
- MULTU 0xFFFFFFFF × 0x00000002 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 → lo=3, hi=1.
- Divide by zero:
  - DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234.
  - DIV 7/0 → lo=0xFFFFFFFF, hi=7.
  - DIV -7/0 → lo=0x00000001, hi=0xFFFFFFF9.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A while idle → hi/lo update on the next edge, busy never asserts. Repeat both with busy=1 → hi/lo unchanged.
- MULT started, flush at cycle 10 of CALC → busy=0 next cycle, hi/lo keep their prior values, no done. Then start a new DIVU 100/7 → lo=14, hi=2.
